// File: rtl/planificador_cubos.sv
`default_nettype none
// ============================================================================
// Module   : planificador_cubos
// Purpose  : Schedules falling-cube launches for Canasta. While enabled, one
//            cube is launched every PERIODO frame ticks into the lowest free
//            slot. Each launch gets a pseudo-random column from an 8-bit LFSR.
//            Slot occupancy is tracked, and a slot is released when its cube
//            reports that it has finished.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            habilitar_cubos     - level, cubes may fall while high
//            tick                - one-cycle pulse per video frame
//            cubo_terminado[N]   - per-slot "cube finished" pulse
//            lanzar[N]           - one-hot start pulse for a slot
//            columna[3]          - column of the most recent launch
//            cubos_activos[N]    - occupancy bit per slot
//            cuenta_lanzados[8]  - launches since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module planificador_cubos #(
  parameter int          NUM_CUBOS = 4,
  parameter int          PERIODO   = 45,
  parameter logic [7:0]  SEMILLA   = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 habilitar_cubos,
  input  logic                 tick,
  input  logic [NUM_CUBOS-1:0] cubo_terminado,
  output logic [NUM_CUBOS-1:0] lanzar,
  output logic [2:0]           columna,
  output logic [NUM_CUBOS-1:0] cubos_activos,
  output logic [7:0]           cuenta_lanzados
);

  localparam logic [1:0] E_INACTIVO = 2'd0;
  localparam logic [1:0] E_ESPERA   = 2'd1;
  localparam logic [1:0] E_LANZAR   = 2'd2;

  localparam logic [7:0] RECARGA = 8'(PERIODO - 1);

  logic [1:0]           estado_q, estado_d;
  logic [7:0]           contador_q, contador_d;
  logic [NUM_CUBOS-1:0] lanzar_q, lanzar_d;
  logic [2:0]           columna_q, columna_d;
  logic [NUM_CUBOS-1:0] activos_q, activos_d;
  logic [7:0]           cuenta_q, cuenta_d;
  logic [7:0]           lfsr_q, lfsr_d;

  logic [NUM_CUBOS-1:0] libre_oh;
  logic                 hay_libre;
  logic [7:0]           lfsr_sig;

  // Lowest free slot, taken from the registered occupancy so a slot freed at
  // one edge can only be reused at the following edge.
  always_comb begin
    libre_oh  = '0;
    hay_libre = 1'b0;
    for (int i = 0; i < NUM_CUBOS; i++) begin
      if (!activos_q[i] && !hay_libre) begin
        libre_oh[i] = 1'b1;
        hay_libre   = 1'b1;
      end
    end
  end

  assign lfsr_sig = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    lanzar_d   = '0;
    columna_d  = columna_q;
    activos_d  = activos_q & ~cubo_terminado;
    cuenta_d   = cuenta_q;
    lfsr_d     = lfsr_q;

    if (!habilitar_cubos) begin
      // Disabling drops every slot and any pending launch; column, launch
      // count and LFSR survive so the sequence continues on re-enable.
      estado_d  = E_INACTIVO;
      activos_d = '0;
    end else begin
      case (estado_q)
        E_INACTIVO: begin
          estado_d   = E_ESPERA;
          contador_d = RECARGA;
        end
        E_ESPERA: begin
          if (tick) begin
            if (contador_q == 8'd0) begin
              estado_d = E_LANZAR;
            end else begin
              contador_d = contador_q - 8'd1;
            end
          end
        end
        E_LANZAR: begin
          // With every slot busy the launch stays pending here; ticks are
          // ignored until a slot frees.
          if (hay_libre) begin
            lanzar_d   = libre_oh;
            activos_d  = (activos_q & ~cubo_terminado) | libre_oh;
            columna_d  = lfsr_q[2:0];
            cuenta_d   = cuenta_q + 8'd1;
            lfsr_d     = lfsr_sig;
            contador_d = RECARGA;
            estado_d   = E_ESPERA;
          end
        end
        default: begin
          estado_d = E_INACTIVO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= E_INACTIVO;
      contador_q <= 8'd0;
      lanzar_q   <= '0;
      columna_q  <= 3'd0;
      activos_q  <= '0;
      cuenta_q   <= 8'd0;
      lfsr_q     <= SEMILLA;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      lanzar_q   <= lanzar_d;
      columna_q  <= columna_d;
      activos_q  <= activos_d;
      cuenta_q   <= cuenta_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign lanzar          = lanzar_q;
  assign columna         = columna_q;
  assign cubos_activos   = activos_q;
  assign cuenta_lanzados = cuenta_q;

endmodule
`default_nettype wire

// File: tb/tb_planificador_cubos.sv
`default_nettype none
// ============================================================================
// Module   : tb_planificador_cubos
// Purpose  : Self-checking bench for planificador_cubos (NUM_CUBOS=4,
//            PERIODO=3). A behavioural model predicts each launch when the
//            stimulus that causes it is driven and queues it with its due
//            cycle. A negedge monitor pops the queue and checks the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_planificador_cubos;

  localparam int         N = 4;
  localparam int         P = 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic         clk = 1'b0;
  logic         reset;
  logic         habilitar;
  logic         tick;
  logic [N-1:0] term;
  logic [N-1:0] lanzar;
  logic [2:0]   columna;
  logic [N-1:0] activos;
  logic [7:0]   cuenta;

  planificador_cubos #(.NUM_CUBOS(N), .PERIODO(P), .SEMILLA(SEED)) dut (
    .clk             (clk),
    .reset           (reset),
    .habilitar_cubos (habilitar),
    .tick            (tick),
    .cubo_terminado  (term),
    .lanzar          (lanzar),
    .columna         (columna),
    .cubos_activos   (activos),
    .cuenta_lanzados (cuenta)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [N-1:0] oh;
    logic [2:0]   col;
    logic [7:0]   cnt;
    int           due;
  } exp_t;
  exp_t q[$];

  // Behavioural model of the scheduler
  bit           en_m;
  bit           pend_m;
  int           rem;
  logic [N-1:0] occ;
  logic [7:0]   lfsr_m;
  logic [7:0]   cnt_m;
  logic [2:0]   col_m;

  task automatic m_launch(input int due);
    exp_t e;
    int   s;
    s = -1;
    for (int i = 0; i < N; i++) if (!occ[i] && s < 0) s = i;
    e.oh   = N'(1) << s;
    e.col  = lfsr_m[2:0];
    e.cnt  = cnt_m + 8'd1;
    e.due  = due;
    q.push_back(e);
    occ    = occ | e.oh;
    col_m  = e.col;
    cnt_m  = e.cnt;
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    rem    = P;
    pend_m = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    repeat (3) cycle();
    chk({tag, "_activos"}, activos, occ);
    chk({tag, "_columna"}, columna, col_m);
    chk({tag, "_cuenta"}, cuenta, cnt_m);
  endtask

  task automatic tick_pulse();
    repeat (9) cycle();
    tick = 1'b1;
    if (en_m && !pend_m) begin
      rem--;
      if (rem == 0) begin
        if (occ != {N{1'b1}}) m_launch(cyc + 2);
        else pend_m = 1'b1;
      end
    end
    cycle();
    tick = 1'b0;
  endtask

  task automatic terminar(input int j);
    logic [N-1:0] vis;
    repeat (4) cycle();
    term[j] = 1'b1;
    if (en_m && occ[j]) begin
      occ[j] = 1'b0;
      vis = occ;
      if (pend_m) m_launch(cyc + 2);
    end else begin
      vis = occ;
    end
    cycle();
    term = '0;
    chk("activos_tras_terminar", activos, vis);
  endtask

  task automatic reset_seq();
    reset = 1'b1;
    habilitar = 1'b1;
    repeat (3) begin
      cycle();
      chk("rst_lanzar", lanzar, 0);
    end
    chk("rst_activos", activos, 0);
    chk("rst_columna", columna, 0);
    chk("rst_cuenta", cuenta, 0);
    reset  = 1'b0;
    occ    = '0;
    lfsr_m = SEED;
    cnt_m  = 8'd0;
    col_m  = 3'd0;
    en_m   = 1'b1;
    pend_m = 1'b0;
    rem    = P;
  endtask

  // Launch monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("lanzar", lanzar, e.oh);
        chk("columna_lanz", columna, e.col);
        chk("cuenta_lanz", cuenta, e.cnt);
      end else if (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("lanzar_tarde", lanzar, e.oh);
      end else if (lanzar != '0) begin
        chk("lanzar_espurio", lanzar, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; habilitar = 1'b1; tick = 1'b0; term = '0;
    reset_seq();

    // Periodic launches into slots 0..3
    for (int k = 0; k < 4; k++) begin
      repeat (P) tick_pulse();
      check_state("periodico");
    end

    // Full stall: fifth launch due with every slot busy
    repeat (P) tick_pulse();
    repeat (20) cycle();
    chk("stall_activos", activos, 4'hF);
    terminar(2);
    check_state("stall_relanzar");
    terminar(0);
    repeat (P) tick_pulse();
    check_state("tras_stall");

    // Spurious terminate on an inactive slot
    terminar(3);
    check_state("libera3");
    terminar(3);
    check_state("espurio");

    // Disable with two slots active and a launch pending
    terminar(0);
    repeat (P - 1) tick_pulse();
    repeat (9) cycle();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    habilitar = 1'b0;
    cycle();
    chk("dis_activos", activos, 0);
    chk("dis_lanzar", lanzar, 0);
    chk("dis_columna", columna, col_m);
    chk("dis_cuenta", cuenta, cnt_m);
    occ = '0; en_m = 1'b0; pend_m = 1'b0;
    tick_pulse();
    check_state("deshabilitado");
    habilitar = 1'b1;
    cycle();
    en_m = 1'b1; rem = P;
    repeat (P) tick_pulse();
    check_state("rehabilitado");

    // Reset mid-operation, then 256 launches to wrap the counter
    reset_seq();
    for (int k = 0; k < 256; k++) begin
      repeat (P) tick_pulse();
      check_state("wrap_lanz");
      terminar(0);
    end
    chk("wrap_cuenta", cuenta, 8'd0);

    repeat (5) cycle();
    chk("cola_vacia", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
